mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_core.sv | 58 +++++
 rtl/mdu_unit.sv | 102 ++++++++++
 tb/tb_mdu_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies,
// FSM state type and the op-to-latency decode.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU).
package mdu_pkg;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
  localparam int CNT_W      = 4;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Busy length of an op; zero means the op never enters RUN.
  function automatic logic [CNT_W-1:0] op_cycles(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: op_cycles = CNT_W'(MUL_CYCLES);
      OP_DIV, OP_DIVU:   op_cycles = CNT_W'(DIV_CYCLES);
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: op_cycles = CNT_W'(MUL_CYCLES);
`endif
      default:           op_cycles = '0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result datapath: 64-bit signed/unsigned multiply, signed and
// unsigned divide, and (with MDU_MADD_EN) multiply-accumulate onto {hi,lo}.
// we is low for divide-by-zero and for ops that produce no result.
module mdu_core
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
`endif
  output logic        we,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_ub, div_mb;
  logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign mag_a  = a[31] ? -a : a;
  assign mag_b  = b[31] ? -b : b;
  // Divisors are forced nonzero; a zero divisor is suppressed through we anyway.
  assign div_ub = (b == 32'd0) ? 32'd1 : b;
  assign div_mb = (b == 32'd0) ? 32'd1 : mag_b;
  assign quo_u  = a / div_ub;
  assign rem_u  = a % div_ub;
  assign quo_m  = mag_a / div_mb;
  assign rem_m  = mag_a % div_mb;
  assign quo_s  = (a[31] ^ b[31]) ? -quo_m : quo_m;
  assign rem_s  = a[31] ? -rem_m : rem_m;

  // Select the result for the latched op.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    we     = 1'b0;
    res_hi = '0;
    res_lo = '0;
    case (op)
      OP_MULT:  begin we = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin we = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV:   begin we = (b != 32'd0); res_hi = rem_s; res_lo = quo_s; end
      OP_DIVU:  begin we = (b != 32'd0); res_hi = rem_u; res_lo = quo_u; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin we = 1'b1; {res_hi, res_lo} = {acc_hi, acc_lo} + prod_s; end
      OP_MADDU: begin we = 1'b1; {res_hi, res_lo} = {acc_hi, acc_lo} + prod_u; end
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// HI/LO multiply-divide unit: IDLE/RUN FSM, latency down-counter, shadow
// operand registers and the architectural hi/lo registers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU).
module mdu_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  start_cycles;
  logic [3:0]        op_q;
  logic [31:0]       a_q, b_q;
  logic              accept, launch, done;
  logic              core_we;
  logic [31:0]       core_hi, core_lo;

  assign start_cycles = op_cycles(op);
  assign busy         = (state == ST_RUN);

  mdu_core u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
`ifdef MDU_MADD_EN
    .acc_hi (hi),
    .acc_lo (lo),
`endif
    .we     (core_we),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    launch  = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = start;
        if (start && (start_cycles != '0)) begin
          launch  = 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counter, shadow operands and hi/lo updates.
  always_ff @(posedge clk) begin
    // NOTE: the shadow registers are cleared on reset too, so an aborted op leaves nothing stale.
    if (reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (accept && (op == OP_MTHI)) hi <= a;
      if (accept && (op == OP_MTLO)) lo <= a;
      if (launch) begin
        cnt  <= start_cycles;
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done && core_we) begin
        hi <= core_hi;
        lo <= core_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops
// checked against an arithmetic reference model of the HI/LO unit.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect and busy length of one op.
  task automatic model(input logic [3:0] o, input logic [31:0] x, y, h, l,
                       output logic [31:0] eh, el, output int cyc);
    longint sx, sy, q, r;
    longint unsigned ux, uy, acc, p;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    eh = h;
    el = l;
    cyc = 0;
    case (o)
      OP_MULT:  begin p = sx * sy; eh = p[63:32]; el = p[31:0]; cyc = 5; end
      OP_MULTU: begin p = ux * uy; eh = p[63:32]; el = p[31:0]; cyc = 5; end
      OP_DIV: begin
        cyc = 10;
        if (y != 0) begin q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0]; end
      end
      OP_DIVU: begin
        cyc = 10;
        if (y != 0) begin el = x / y; eh = x % y; end
      end
      OP_MTHI: eh = x;
      OP_MTLO: el = x;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        acc = {h, l};
        p = (o == OP_MADD) ? acc + longint'(sx * sy) : acc + ux * uy;
        eh = p[63:32];
        el = p[31:0];
        cyc = 5;
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op at the current negedge, count busy cycles, check hi/lo.
  // Returns at the negedge where busy is low again, so calls chain back-to-back.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, y, input string name);
    logic [31:0] eh, el;
    int ecyc, n;
    model(o, x, y, hi_m, lo_m, eh, el, ecyc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != ecyc) begin
      errors++;
      $display("FAIL %s busy_cycles op=%0d a=%h b=%h got %0d want %0d", name, o, x, y, n, ecyc);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s hilo op=%0d a=%h b=%h got %h_%h want %h_%h", name, o, x, y, hi, lo, eh, el);
    end
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    // Reset wins over a start of either kind in the same cycle.
    start = 1'b1; op = OP_MTHI; a = 32'hFFFF_0001;
    @(posedge clk); @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4;
    @(posedge clk); @(negedge clk);
    start = 1'b0; reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_priority got busy=%b hi=%h want 0/00000000", busy, hi);
    end
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_directed();
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg_const got %h_%h want ffffffff_fffffffa", hi, lo);
    end
    run_op(OP_DIVU, 32'd7, 32'd2, "divu_7_2");
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++;
      $display("FAIL divu_const got %h_%h want 00000001_00000003", hi, lo);
    end
    run_op(OP_DIV, -32'sd7, 32'd2, "div_m7_2");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg_const got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, "mthi");
    run_op(OP_DIV, 32'd5, 32'd0, "div_by_zero");
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++;
      $display("FAIL div0_hold got hi=%h want 12345678", hi);
    end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow_const got %h_%h want 00000000_80000000", hi, lo);
    end
    run_op(4'd12, 32'hAAAA_5555, 32'd1, "unknown_op");
  endtask

  task automatic test_ignore_start();
    logic [31:0] eh, el;
    int ecyc, n;
    model(OP_MULT, 32'h0001_0003, 32'h0002_0005, hi_m, lo_m, eh, el, ecyc);
    op = OP_MULT; a = 32'h0001_0003; b = 32'h0002_0005; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin op = OP_MTLO; a = 32'hDEAD_BEEF; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ignore_busy_cycles got %0d want 5", n);
    end
    checks++;
    if (lo !== el || hi !== eh) begin
      errors++;
      $display("FAIL ignore_mtlo got %h_%h want %h_%h", hi, lo, eh, el);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic test_reset_abort();
    run_op(OP_MTHI, 32'h5A5A_5A5A, 32'd0, "pre_abort_mthi");
    run_op(OP_MTLO, 32'hA5A5_A5A5, 32'd0, "pre_abort_mtlo");
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    hi_m = '0; lo_m = '0;
    run_op(OP_MULTU, 32'd2, 32'd3, "multu_after_reset");
    checks++;
    if (lo !== 32'd6) begin
      errors++;
      $display("FAIL multu_2x3 got lo=%h want 00000006", lo);
    end
  endtask

  task automatic test_back_to_back();
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b2b_mult");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10, "b2b_divu");
    run_op(OP_MTLO, 32'h0BAD_F00D, 32'd0, "b2b_mtlo");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_multu");
  endtask

  task automatic test_madd();
`ifdef MDU_MADD_EN
    run_op(OP_MTHI, 32'd0, 32'd0, "madd_set_hi");
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, "madd_set_lo");
    run_op(OP_MADDU, 32'd1, 32'd1, "maddu_carry");
    checks++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL maddu_carry_const got %h_%h want 00000001_00000000", hi, lo);
    end
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd5, "madd_neg");
`else
    run_op(OP_MADD, 32'd9, 32'd9, "madd_disabled");
    run_op(OP_MADDU, 32'd9, 32'd9, "maddu_disabled");
`endif
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o > 4'd7 && $urandom_range(0, 3) != 0) o = 4'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(o, x, y, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_madd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
